audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCK_LOG2, default 3, meaning bit-clock period = 2^BCK_LOG2 clk cycles (legal 1..6); B = 2^BCK_LOG2, frame F = 64*B clk.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  high = run serializer; low = hold idle.
REQ-005 SHALL have port left_audio  input  16  signed left sample from the PCM/mixer stage.
REQ-006 SHALL have port right_audio  input  16  signed right sample from the PCM/mixer stage.
REQ-007 SHALL have port next_sample  output  1  one-clk strobe requesting the next sample pair upstream.
REQ-008 SHALL have port i2s_bck  output  1  I2S bit clock.
REQ-009 SHALL have port i2s_lrck  output  1  I2S word select, 0 = left, 1 = right.
REQ-010 SHALL have port i2s_data  output  1  I2S serial data, MSB first.

Function
REQ-011 SHALL hold a frame counter cnt of width 6+BCK_LOG2: +1 per clk while enable=1, wraps F-1 -> 0; slot = cnt[top 6 bits] (0..63), phase = cnt[BCK_LOG2-1:0].
REQ-012 SHALL drive i2s_bck = cnt[BCK_LOG2-1] and i2s_lrck = cnt[MSB] directly from register bits (glitch-free; bck low first half of each slot, so bck falls where phase wraps to 0).
REQ-013 SHALL hold a 64-bit frame shift register; i2s_data = its bit 63.
REQ-014 SHALL, on the enabled edge where cnt wraps F-1 -> 0, load it with {1'b0, left_audio, 16'b0, right_audio, 15'b0}, capturing both inputs on that same edge.
REQ-015 SHALL, on every other enabled edge where phase becomes 0, shift it left one bit, filling 0.
REQ-016 Resulting slot map per frame SHALL be: slot 0 = 0; slots 1..16 = left[15:0]; slots 17..32 = 0; slots 33..48 = right[15:0]; slots 49..63 = 0 (standard I2S one-bit delay after lrck edge).
REQ-017 SHALL drive next_sample high for exactly the one clk cycle following each enabled wrap edge, i.e. once per F cycles; never while enable=0.
REQ-018 Latency SHALL be: the pair present at a wrap edge goes out in the frame starting at that edge; upstream therefore has F-1 cycles after next_sample to settle new samples before the next wrap.
REQ-019 Inputs SHALL be sampled only at wrap edges; input changes mid-frame SHALL NOT affect the frame being sent.
REQ-020 SHALL, while enable=0, synchronously force cnt=0 and frame register=0, so i2s_bck, i2s_lrck, i2s_data and next_sample read 0 from the next edge on.
REQ-021 SHALL, when enable rises, advance cnt 0->1 on the first enabled edge with no load, so the first frame after enable carries all-zero data; the first next_sample follows the first wrap, F clk later.
REQ-022 SHALL, when enable drops mid-frame, abandon the frame with no completion and no strobe.
REQ-023 Sample data SHALL be passed bit-exact with no arithmetic or truncation; sign is carried by MSB.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, clear cnt, frame register and next_sample, driving all outputs 0.
REQ-025 SHALL, on rst_n release, behave as enable rising (REQ-021) if enable=1.
REQ-026 SHALL, on reset asserted mid-frame, discard that frame with no strobe.

Verification (BCK_LOG2=3, B=8, F=512)
REQ-027 Reset then enable=1, left=16'hA5F0, right=16'h8001 held -> frame 0 all-zero data; next_sample pulses at clk 512, 1024, ...; frame 1 slots 1..16 = 1010010111110000, slots 33..48 = 1000000000000001, others 0.
REQ-028 Check timing -> i2s_bck period 8 clk at 50% duty; i2s_lrck low slots 0..31, high slots 32..63; i2s_data changes only at bck falling edges; exactly one next_sample per 512 clk.
REQ-029 Change left from 16'h1234 to 16'hFFFF at clk 100 of a frame -> current frame still sends 16'h1234; next frame sends 16'hFFFF.
REQ-030 Deassert enable at slot 20 -> all outputs 0 from next edge and no strobe; reassert -> zero frame, then strobe 512 clk later, then normal data.
REQ-031 Assert rst_n=0 asynchronously between clk edges mid-frame -> outputs 0 immediately; after release same behaviour as REQ-027.
REQ-032 Upstream model updates samples 8 clk after each next_sample with values 1,2,3... -> frames carry 1,2,3 in order, none dropped or repeated.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo 16-bit I2S transmitter.
// Each frame has 64 bit-clock slots. Left is sent in slots 1..16 and right in
// slots 33..48, MSB first, with the usual one-bit delay after the lrck edge.
// The upstream stage is asked for the next sample pair once per frame.
module audio_i2s_tx #(
  parameter int BCK_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] left_audio,
  input  logic [15:0] right_audio,
  output logic        next_sample,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data
);

  localparam int CW = 6 + BCK_LOG2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   frame_q, frame_d;
  logic          next_sample_q, next_sample_d;
  logic          wrap;
  logic          phase_wrap;

  // The counter is at the last clk of the frame: the next enabled edge starts a new frame.
  assign wrap       = (cnt_q == {CW{1'b1}});
  // The counter is at the last clk of a slot: the next enabled edge starts a new slot.
  assign phase_wrap = (cnt_q[BCK_LOG2-1:0] == {BCK_LOG2{1'b1}});

  // Next state: advance the counter, load or shift the frame, and raise the request strobe.
  // Everything is forced to zero while the serializer is disabled.
  always_comb begin
    cnt_d         = '0;
    frame_d       = '0;
    next_sample_d = 1'b0;
    if (enable) begin
      cnt_d   = cnt_q + CW'(1);
      frame_d = frame_q;
      if (wrap) begin
        frame_d       = {1'b0, left_audio, 16'b0, right_audio, 15'b0};
        next_sample_d = 1'b1;
      end else if (phase_wrap) begin
        frame_d = {frame_q[62:0], 1'b0};
      end
    end
  end

  // State registers. Asynchronous reset clears the frame in flight with no strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_q       <= '0;
      next_sample_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      next_sample_q <= next_sample_d;
    end
  end

  // All outputs come straight from flops so that the I2S lines are glitch-free.
  assign i2s_bck     = cnt_q[BCK_LOG2-1];
  assign i2s_lrck    = cnt_q[CW-1];
  assign i2s_data    = frame_q[63];
  assign next_sample = next_sample_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench for audio_i2s_tx.
// The stimulus process acts as the upstream sample source. Each time the DUT
// latches a pair, the source pushes that pair, and it pushes an all-zero frame
// whenever a run starts. An independent monitor acts as an I2S receiver. It
// rebuilds every frame from bck/lrck/data and pops and compares it against the
// queue. On every clk it also checks bit-clock, word-select and strobe timing
// against simple arithmetic on the number of enabled clocks.
module tb_audio_i2s_tx;

  localparam int BCK_LOG2 = 3;
  localparam int B        = 1 << BCK_LOG2;
  localparam int F        = 64 * B;

  typedef enum {HOLD, RANDOM, SEQ} modeT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] left_audio = '0;
  logic [15:0] right_audio = '0;
  logic        next_sample;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          framesChecked = 0;
  logic [31:0] expQ[$];

  modeT        mode = HOLD;
  int          sinceStrobe = -1;
  int          upd1 = 0;
  int          upd2 = 0;
  logic [15:0] seqVal = '0;

  audio_i2s_tx #(.BCK_LOG2(BCK_LOG2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .left_audio  (left_audio),
    .right_audio (right_audio),
    .next_sample (next_sample),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Expected 64-slot frame, built slot by slot from the I2S slot map.
  function automatic logic [63:0] expFrame(input logic [31:0] pair);
    logic [63:0] f;
    logic [15:0] l;
    logic [15:0] r;
    l = pair[31:16];
    r = pair[15:0];
    f = '0;
    for (int s = 0; s < 64; s++) begin
      if (s >= 1 && s <= 16) f[63-s] = l[16-s];
      else if (s >= 33 && s <= 48) f[63-s] = r[48-s];
    end
    return f;
  endfunction

  // Upstream source model, one clk per iteration, acting on the falling edge.
  // On each request strobe it records the pair the DUT has just latched, then
  // updates its outputs later in the frame according to the current mode.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n && enable && next_sample) begin
        expQ.push_back({left_audio, right_audio});
        sinceStrobe = 0;
        upd1 = $urandom_range(1, 300);
        upd2 = $urandom_range(301, 480);
      end else if (sinceStrobe >= 0) begin
        sinceStrobe++;
      end
      if (mode == RANDOM && (sinceStrobe == upd1 || sinceStrobe == upd2)) begin
        left_audio  = 16'($urandom);
        right_audio = 16'($urandom);
      end
      if (mode == SEQ && sinceStrobe == 8) begin
        seqVal      = seqVal + 16'd1;
        left_audio  = seqVal;
        right_audio = seqVal ^ 16'h8000;
      end
    end
  endtask

  // Start a run. The first frame after enable always carries zero data.
  task automatic startRun();
    rst_n  = 1'b1;
    enable = 1'b1;
    sinceStrobe = -1;
    expQ.push_back(32'h0);
  endtask

  // Stop a run. Whatever frame was in flight is abandoned.
  task automatic stopRun();
    enable = 1'b0;
    sinceStrobe = -1;
    expQ.delete();
  endtask

  // Advance until the DUT requests a sample pair, with a bounded wait.
  task automatic waitStrobe();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * F && !found; i++) begin
      applyStimulus(1);
      found = rst_n && enable && next_sample;
    end
    checkOutput("strobe wait", 64'(found), 64'd1);
  endtask

  // Monitor: per-clk timing checks, plus an I2S receiver that feeds the scoreboard.
  initial begin
    int          runCyc;
    int          c;
    int          slot;
    logic        prevBck;
    logic        prevData;
    logic        lastRiseLrck;
    logic [63:0] rx;
    logic [31:0] pair;
    runCyc = 0;
    slot = -1;
    prevBck = 1'b0;
    prevData = 1'b0;
    lastRiseLrck = 1'b0;
    rx = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !enable) begin
        runCyc = 0;
        slot = -1;
        checkOutput("idle outputs", 64'({next_sample, i2s_bck, i2s_lrck, i2s_data}), 64'd0);
      end else begin
        runCyc++;
        c = runCyc % F;
        checkOutput("bck", 64'(i2s_bck), 64'((c % B) >= B / 2));
        checkOutput("lrck", 64'(i2s_lrck), 64'(c >= F / 2));
        checkOutput("next_sample", 64'(next_sample), 64'(c == 0));
        if (runCyc >= 2)
          checkOutput("data change off bck fall", 64'((i2s_data != prevData) && !(prevBck && !i2s_bck)), 64'd0);
        if (i2s_bck && !prevBck) begin
          if (!i2s_lrck && (slot < 0 || lastRiseLrck)) slot = 0;
          else if (slot >= 0) slot++;
          lastRiseLrck = i2s_lrck;
          if (slot >= 0 && slot <= 63) rx[63-slot] = i2s_data;
          if (slot == 63) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpected frame", 64'd1, 64'd0);
            end else begin
              pair = expQ.pop_front();
              checkOutput("frame data", rx, expFrame(pair));
              framesChecked++;
            end
          end
        end
      end
      prevBck = i2s_bck;
      prevData = i2s_data;
    end
  end

  // Hang guard.
  initial begin
    #(600_000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    mode = HOLD;
    left_audio = 16'hA5F0;
    right_audio = 16'h8001;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4);

    // Held pair: zero frame, then A5F0 / 8001 every frame.
    startRun();
    applyStimulus(3 * F);

    // Random pairs, with some updates landing mid-frame.
    mode = RANDOM;
    applyStimulus(6 * F);

    // Mid-frame change: 1234 stays in the frame already latched, FFFF goes out next.
    mode = HOLD;
    waitStrobe();
    left_audio = 16'h1234;
    waitStrobe();
    applyStimulus(99);
    left_audio = 16'hFFFF;
    applyStimulus(2 * F);

    // Disable at slot 20, idle for a while, then restart with sequential values.
    waitStrobe();
    applyStimulus(20 * B + 2);
    stopRun();
    applyStimulus(30);
    mode = SEQ;
    seqVal = 16'd1;
    left_audio = seqVal;
    right_audio = seqVal ^ 16'h8000;
    startRun();
    applyStimulus(5 * F);

    // Asynchronous reset between edges while bck and lrck are both high.
    mode = HOLD;
    waitStrobe();
    applyStimulus(300);
    #2;
    rst_n = 1'b0;
    sinceStrobe = -1;
    expQ.delete();
    #1;
    checkOutput("async reset outputs", 64'({next_sample, i2s_bck, i2s_lrck, i2s_data}), 64'd0);
    left_audio = 16'hA5F0;
    right_audio = 16'h8001;
    applyStimulus(3);
    startRun();
    applyStimulus(3 * F);

    // Random enable drops at arbitrary points.
    mode = RANDOM;
    repeat (3) begin
      applyStimulus($urandom_range(100, 2 * F));
      stopRun();
      applyStimulus($urandom_range(1, 20));
      startRun();
    end
    applyStimulus(2 * F);

    checkOutput("frames left pending", 64'(expQ.size() <= 1), 64'd1);
    checkOutput("enough frames received", 64'(framesChecked >= 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
